axi_cache_rd_arbiter: RTL and testbench

Shares the SoC's single AXI4 read port to memory between the instruction cache (ibus) and the data cache (dbus).
- Round-robin arbitration; one outstanding burst at a time.
- Read-data beats are routed back to the requester that owns the current burst.
- Sits between the core's icache/dcache refill ports and the interconnect.
- Also reports burst-length protocol errors and occupancy for bench instrumentation.

---
 rtl/axi_cache_rd_arbiter.sv | 173 +++++++++++++++++
 tb/tb_axi_cache_rd_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cache_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port between the instruction
// cache (ibus, index 0) and the data cache (dbus, index 1). One burst is
// outstanding at a time; R beats are routed back to the burst owner with
// zero latency, and burst-length mismatches are flagged on io_err_len.
module axi_cache_rd_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8
) (
    input  logic              io_axiClk,
    input  logic              io_asyncResetn,
    // instruction cache refill port
    input  logic              io_ibus_ar_valid,
    output logic              io_ibus_ar_ready,
    input  logic [ADDR_W-1:0] io_ibus_ar_addr,
    input  logic [LEN_W-1:0]  io_ibus_ar_len,
    output logic              io_ibus_r_valid,
    input  logic              io_ibus_r_ready,
    output logic [DATA_W-1:0] io_ibus_r_data,
    output logic [1:0]        io_ibus_r_resp,
    output logic              io_ibus_r_last,
    // data cache refill port
    input  logic              io_dbus_ar_valid,
    output logic              io_dbus_ar_ready,
    input  logic [ADDR_W-1:0] io_dbus_ar_addr,
    input  logic [LEN_W-1:0]  io_dbus_ar_len,
    output logic              io_dbus_r_valid,
    input  logic              io_dbus_r_ready,
    output logic [DATA_W-1:0] io_dbus_r_data,
    output logic [1:0]        io_dbus_r_resp,
    output logic              io_dbus_r_last,
    // shared memory read port
    output logic              io_mem_ar_valid,
    input  logic              io_mem_ar_ready,
    output logic [ADDR_W-1:0] io_mem_ar_addr,
    output logic [LEN_W-1:0]  io_mem_ar_len,
    output logic [2:0]        io_mem_ar_size,
    output logic [1:0]        io_mem_ar_burst,
    input  logic              io_mem_r_valid,
    output logic              io_mem_r_ready,
    input  logic [DATA_W-1:0] io_mem_r_data,
    input  logic [1:0]        io_mem_r_resp,
    input  logic              io_mem_r_last,
    // status
    output logic              io_busy,
    output logic              io_grant,
    output logic              io_err_len
);

    localparam logic [2:0] AR_SIZE = 3'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t             state_reg;
    logic               grant_reg;
    logic               prio_reg;
    logic               mem_ar_valid_reg;
    logic               err_len_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W:0]     cnt_reg;

    logic [1:0]         req_valid;
    logic [1:0]         req_r_ready;
    logic [1:0]         ar_ready_vec;
    logic [1:0]         r_sel_vec;
    logic [1:0]         r_valid_vec;
    logic [1:0]         r_last_vec;
    logic [1:0]         r_resp_vec [2];
    logic [DATA_W-1:0]  r_data_vec [2];

    logic               win;
    logic               arb_fire;
    logic               r_fire;
    logic               at_len;
    logic [ADDR_W-1:0]  win_addr;
    logic [LEN_W-1:0]   win_len;

    assign req_valid   = {io_dbus_ar_valid, io_ibus_ar_valid};
    assign req_r_ready = {io_dbus_r_ready, io_ibus_r_ready};

    // Winner: the sole requester, or the priority pointer on a tie.
    always_comb begin
        win      = (&req_valid) ? prio_reg : req_valid[1];
        win_addr = win ? io_dbus_ar_addr : io_ibus_ar_addr;
        win_len  = win ? io_dbus_ar_len  : io_ibus_ar_len;
    end

    assign arb_fire = (state_reg == IDLE) && (|req_valid);
    assign r_fire   = io_mem_r_valid && io_mem_r_ready;
    assign at_len   = (cnt_reg == {1'b0, len_reg});

    // Per-requester handshake and R-channel routing; non-owners see zeros.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign ar_ready_vec[gi] = arb_fire && (win == 1'(gi));
            assign r_sel_vec[gi]    = (state_reg == DATA) && (grant_reg == 1'(gi));
            assign r_valid_vec[gi]  = r_sel_vec[gi] && io_mem_r_valid;
            assign r_data_vec[gi]   = r_sel_vec[gi] ? io_mem_r_data : '0;
            assign r_resp_vec[gi]   = r_sel_vec[gi] ? io_mem_r_resp : 2'b00;
            assign r_last_vec[gi]   = r_sel_vec[gi] && io_mem_r_last;
        end
    endgenerate

    assign io_ibus_ar_ready = ar_ready_vec[0];
    assign io_dbus_ar_ready = ar_ready_vec[1];
    assign io_ibus_r_valid  = r_valid_vec[0];
    assign io_dbus_r_valid  = r_valid_vec[1];
    assign io_ibus_r_data   = r_data_vec[0];
    assign io_dbus_r_data   = r_data_vec[1];
    assign io_ibus_r_resp   = r_resp_vec[0];
    assign io_dbus_r_resp   = r_resp_vec[1];
    assign io_ibus_r_last   = r_last_vec[0];
    assign io_dbus_r_last   = r_last_vec[1];

    assign io_mem_r_ready  = (state_reg == DATA) && req_r_ready[grant_reg];
    assign io_mem_ar_valid = mem_ar_valid_reg;
    assign io_mem_ar_addr  = addr_reg;
    assign io_mem_ar_len   = len_reg;
    assign io_mem_ar_size  = AR_SIZE;
    assign io_mem_ar_burst = 2'b01;
    assign io_busy         = (state_reg != IDLE);
    assign io_grant        = grant_reg;
    assign io_err_len      = err_len_reg;

    // Burst FSM: capture winner, present address, count beats, rotate priority.
    always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            state_reg        <= IDLE;
            grant_reg        <= 1'b0;
            prio_reg         <= 1'b0;
            mem_ar_valid_reg <= 1'b0;
            err_len_reg      <= 1'b0;
            addr_reg         <= '0;
            len_reg          <= '0;
            cnt_reg          <= '0;
        end else begin
            err_len_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (arb_fire) begin
                        addr_reg         <= win_addr;
                        len_reg          <= win_len;
                        grant_reg        <= win;
                        mem_ar_valid_reg <= 1'b1;
                        state_reg        <= ADDR;
                    end
                end
                ADDR: begin
                    if (io_mem_ar_ready) begin
                        mem_ar_valid_reg <= 1'b0;
                        cnt_reg          <= '0;
                        state_reg        <= DATA;
                    end
                end
                DATA: begin
                    if (r_fire) begin
                        cnt_reg <= cnt_reg + (LEN_W+1)'(1);
                        // last on the wrong beat, or the expected last beat lacks it
                        if (io_mem_r_last != at_len)
                            err_len_reg <= 1'b1;
                        if (io_mem_r_last) begin
                            prio_reg  <= ~grant_reg;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_cache_rd_arbiter.sv
// Directed bench for axi_cache_rd_arbiter: arbitration order, address
// hold, beat routing under back-pressure, length errors and async reset.
module tb_axi_cache_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ib_ar_valid, ib_ar_ready, ib_r_valid, ib_r_ready, ib_r_last;
    logic [63:0] ib_ar_addr, ib_r_data;
    logic [7:0]  ib_ar_len;
    logic [1:0]  ib_r_resp;
    logic        db_ar_valid, db_ar_ready, db_r_valid, db_r_ready, db_r_last;
    logic [63:0] db_ar_addr, db_r_data;
    logic [7:0]  db_ar_len;
    logic [1:0]  db_r_resp;
    logic        mem_ar_valid, mem_ar_ready, mem_r_valid, mem_r_ready, mem_r_last;
    logic [63:0] mem_ar_addr, mem_r_data;
    logic [7:0]  mem_ar_len;
    logic [2:0]  mem_ar_size;
    logic [1:0]  mem_ar_burst, mem_r_resp;
    logic        busy, grant, err_len;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_cache_rd_arbiter dut (
        .io_axiClk(clk), .io_asyncResetn(rst_n),
        .io_ibus_ar_valid(ib_ar_valid), .io_ibus_ar_ready(ib_ar_ready),
        .io_ibus_ar_addr(ib_ar_addr), .io_ibus_ar_len(ib_ar_len),
        .io_ibus_r_valid(ib_r_valid), .io_ibus_r_ready(ib_r_ready),
        .io_ibus_r_data(ib_r_data), .io_ibus_r_resp(ib_r_resp), .io_ibus_r_last(ib_r_last),
        .io_dbus_ar_valid(db_ar_valid), .io_dbus_ar_ready(db_ar_ready),
        .io_dbus_ar_addr(db_ar_addr), .io_dbus_ar_len(db_ar_len),
        .io_dbus_r_valid(db_r_valid), .io_dbus_r_ready(db_r_ready),
        .io_dbus_r_data(db_r_data), .io_dbus_r_resp(db_r_resp), .io_dbus_r_last(db_r_last),
        .io_mem_ar_valid(mem_ar_valid), .io_mem_ar_ready(mem_ar_ready),
        .io_mem_ar_addr(mem_ar_addr), .io_mem_ar_len(mem_ar_len),
        .io_mem_ar_size(mem_ar_size), .io_mem_ar_burst(mem_ar_burst),
        .io_mem_r_valid(mem_r_valid), .io_mem_r_ready(mem_r_ready),
        .io_mem_r_data(mem_r_data), .io_mem_r_resp(mem_r_resp), .io_mem_r_last(mem_r_last),
        .io_busy(busy), .io_grant(grant), .io_err_len(err_len)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Check held address for 'hold' cycles, then complete the AR handshake.
    task automatic addr_phase(input logic [63:0] a, input logic [7:0] l, input int hold);
        for (int i = 0; i <= hold; i++) begin
            mem_ar_ready = (i == hold);
            #1;
            chk("ar_valid", mem_ar_valid, 1);
            chk("ar_addr", mem_ar_addr, a);
            chk("ar_len", mem_ar_len, l);
            step();
        end
        mem_ar_ready = 1'b0;
        chk("ar_valid_drop", mem_ar_valid, 0);
    endtask

    // One accepted beat for owner; err_exp is the io_err_len value after the edge.
    task automatic beat(input bit owner, input logic [63:0] d, input bit last, input bit err_exp);
        mem_r_valid = 1'b1; mem_r_data = d; mem_r_resp = d[1:0]; mem_r_last = last;
        ib_r_ready = !owner; db_r_ready = owner;
        #1;
        chk("own_r_valid", owner ? db_r_valid : ib_r_valid, 1);
        chk("other_r_valid", owner ? ib_r_valid : db_r_valid, 0);
        chk("own_r_data", owner ? db_r_data : ib_r_data, d);
        chk("own_r_last", owner ? db_r_last : ib_r_last, last);
        chk("mem_r_ready", mem_r_ready, 1);
        step();
        mem_r_valid = 1'b0; mem_r_last = 1'b0;
        chk("err_len", err_len, err_exp);
        $display("beat owner=%0d data=%0h last=%0d busy=%0d err=%0d", owner, d, last, busy, err_len);
    endtask

    initial begin
        int k;
        ib_ar_valid = 0; ib_ar_addr = 0; ib_ar_len = 0; ib_r_ready = 0;
        db_ar_valid = 0; db_ar_addr = 0; db_ar_len = 0; db_r_ready = 0;
        mem_ar_ready = 0; mem_r_valid = 0; mem_r_data = 0; mem_r_resp = 0; mem_r_last = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_ar_valid", mem_ar_valid, 0);
        chk("rst_err", err_len, 0);
        chk("rst_r_ready", mem_r_ready, 0);
        do_reset();

        // 1: single ibus burst, len 3
        ib_ar_valid = 1; ib_ar_addr = 64'h8000_0000; ib_ar_len = 8'd3;
        #1;
        chk("t1_ib_ar_ready", ib_ar_ready, 1);
        chk("t1_db_ar_ready", db_ar_ready, 0);
        chk("t1_ar_valid_lat", mem_ar_valid, 0);
        step();
        ib_ar_valid = 0;
        chk("t1_size", mem_ar_size, 3);
        chk("t1_burst", mem_ar_burst, 1);
        chk("t1_grant", grant, 0);
        chk("t1_busy", busy, 1);
        addr_phase(64'h8000_0000, 8'd3, 0);
        for (int i = 0; i < 4; i++) beat(0, 64'h1000 + 64'(i), i == 3, 0);
        chk("t1_busy_end", busy, 0);
        $display("t1 done checks=%0d", checks);

        // 2: round robin after reset
        do_reset();
        ib_ar_valid = 1; ib_ar_addr = 64'hA000; ib_ar_len = 0;
        db_ar_valid = 1; db_ar_addr = 64'hB000; db_ar_len = 0;
        #1;
        chk("t2_ib_first", ib_ar_ready, 1);
        chk("t2_db_wait", db_ar_ready, 0);
        step();
        ib_ar_valid = 0;
        #1;
        chk("t2_grant0", grant, 0);
        chk("t2_db_blocked", db_ar_ready, 0);
        addr_phase(64'hA000, 8'd0, 0);
        beat(0, 64'h2000, 1, 0);
        ib_ar_valid = 1; ib_ar_addr = 64'hC000;
        #1;
        chk("t2_db_second", db_ar_ready, 1);
        chk("t2_ib_wait", ib_ar_ready, 0);
        step();
        db_ar_valid = 0;
        chk("t2_grant1", grant, 1);
        addr_phase(64'hB000, 8'd0, 0);
        beat(1, 64'h2001, 1, 0);
        db_ar_valid = 1; db_ar_addr = 64'hD000;
        #1;
        chk("t2_ib_third", ib_ar_ready, 1);
        chk("t2_db_third", db_ar_ready, 0);
        step();
        ib_ar_valid = 0; db_ar_valid = 0;
        chk("t2_grant0b", grant, 0);
        addr_phase(64'hC000, 8'd0, 0);
        beat(0, 64'h2002, 1, 0);
        $display("t2 done checks=%0d", checks);

        // 3: dbus len 7, delayed AR, toggling r_ready
        db_ar_valid = 1; db_ar_addr = 64'h4000_0100; db_ar_len = 8'd7;
        #1;
        chk("t3_db_ar_ready", db_ar_ready, 1);
        step();
        db_ar_valid = 0; db_ar_addr = 0; db_ar_len = 0;
        addr_phase(64'h4000_0100, 8'd7, 5);
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            db_r_ready = (c % 2 == 0);
            mem_r_valid = 1; mem_r_data = 64'h300 + 64'(k); mem_r_last = (k == 7);
            #1;
            chk("t3_r_valid", db_r_valid, 1);
            chk("t3_r_data", db_r_data, 64'h300 + 64'(k));
            chk("t3_r_ready_mirror", mem_r_ready, db_r_ready);
            chk("t3_ib_quiet", ib_r_valid, 0);
            chk("t3_busy", busy, 1);
            if (db_r_ready) k++;
            step();
        end
        mem_r_valid = 0; mem_r_last = 0; db_r_ready = 0;
        chk("t3_beats", 64'(k), 8);
        chk("t3_idle", busy, 0);
        chk("t3_no_err", err_len, 0);
        $display("t3 done beats=%0d", k);

        // 4a: early r_last on beat 2 of len 3
        ib_ar_valid = 1; ib_ar_addr = 64'h5000; ib_ar_len = 8'd3;
        step();
        ib_ar_valid = 0;
        addr_phase(64'h5000, 8'd3, 1);
        beat(0, 64'h40, 0, 0);
        beat(0, 64'h41, 0, 0);
        beat(0, 64'h42, 1, 1);
        chk("t4a_idle", busy, 0);
        step();
        chk("t4a_pulse_end", err_len, 0);

        // 4b: r_last missing on beat 4, arrives on beat 5
        ib_ar_valid = 1; ib_ar_addr = 64'h6000; ib_ar_len = 8'd3;
        step();
        ib_ar_valid = 0;
        addr_phase(64'h6000, 8'd3, 0);
        for (int i = 0; i < 3; i++) beat(0, 64'h50 + 64'(i), 0, 0);
        beat(0, 64'h53, 0, 1);
        chk("t4b_still_busy", busy, 1);
        beat(0, 64'h54, 1, 1);
        chk("t4b_idle", busy, 0);
        step();
        chk("t4b_pulse_end", err_len, 0);

        // 5: async reset mid-DATA
        ib_ar_valid = 1; ib_ar_addr = 64'h7000; ib_ar_len = 8'd3;
        step();
        ib_ar_valid = 0;
        addr_phase(64'h7000, 8'd3, 0);
        beat(0, 64'h60, 0, 0);
        mem_r_valid = 1; mem_r_data = 64'h61; ib_r_ready = 1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_r_valid", ib_r_valid, 0);
        chk("t5_r_data", ib_r_data, 0);
        chk("t5_busy", busy, 0);
        chk("t5_mem_r_ready", mem_r_ready, 0);
        chk("t5_ar_valid", mem_ar_valid, 0);
        chk("t5_grant", grant, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("t5_stale_ready", mem_r_ready, 0);
        chk("t5_stale_valid", ib_r_valid, 0);
        ib_ar_valid = 1; ib_ar_addr = 64'h8000_2000; ib_ar_len = 8'd1;
        step();
        ib_ar_valid = 0;
        chk("t5_addr_stale_ready", mem_r_ready, 0);
        chk("t5_addr_stale_valid", ib_r_valid, 0);
        addr_phase(64'h8000_2000, 8'd1, 0);
        beat(0, 64'h70, 0, 0);
        beat(0, 64'h71, 1, 0);
        chk("t5_done", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
